// File: rtl/pipe_hazard_if.sv
// Hazard-controller bundle: pipeline status in, per-stage hold/bubble controls out.
// The master side is the pipeline datapath; the slave side is pipe_hazard_ctrl.
interface pipe_hazard_if #(
  parameter int RA_W   = 5,
  parameter int PERF_W = 16
);
  logic [RA_W-1:0]   id_rs1;
  logic [RA_W-1:0]   id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [RA_W-1:0]   ex_rd;
  logic              ex_is_load;
  logic              ex_jb;
  logic              ex_muldiv;
  logic              icache_stall;
  logic              dcache_stall;

  logic              stall_f;
  logic              stall_d;
  logic              stall_e;
  logic              flush_d;
  logic              flush_e;
  logic              flush_m;
  logic              cache_stall;
  logic              muldiv_busy;
  logic [PERF_W-1:0] stall_cnt;
  logic              dbg_state;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_jb, ex_muldiv, icache_stall, dcache_stall,
    input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           cache_stall, muldiv_busy, stall_cnt, dbg_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_jb, ex_muldiv, icache_stall, dcache_stall,
    output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           cache_stall, muldiv_busy, stall_cnt, dbg_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, mul/div occupancy and
// cache freezes, with redirects deferred (not dropped) across a freeze.
module pipe_hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int RA_W       = 5,
  parameter int PERF_W     = 16
) (
  input logic          clk,
  input logic          rst_n,
  pipe_hazard_if.slave hz
);
  localparam int CNT_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_MULDIV = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_jb_q, pend_jb_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic freeze;
  logic jb_eff;
  logic load_use;
  logic stall_f_c, stall_d_c, stall_e_c;
  logic flush_d_c, flush_e_c, flush_m_c;

  assign freeze   = hz.icache_stall | hz.dcache_stall;
  assign jb_eff   = (hz.ex_jb | pend_jb_q) & ~freeze;
  assign load_use = hz.ex_is_load & (hz.ex_rd != '0) &
                    ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_jb_d = pend_jb_q;
    stall_f_c = 1'b0;
    stall_d_c = 1'b0;
    stall_e_c = 1'b0;
    flush_d_c = 1'b0;
    flush_e_c = 1'b0;
    flush_m_c = 1'b0;

    // A freeze holds every pipeline register, so only remember any redirect seen meanwhile.
    if (freeze) begin
      pend_jb_d = pend_jb_q | hz.ex_jb;
    end else begin
      pend_jb_d = 1'b0;
      case (state_q)
        ST_RUN: begin
          if (jb_eff) begin
            flush_d_c = 1'b1;
            flush_e_c = 1'b1;
          end else if (hz.ex_muldiv) begin
            state_d   = ST_MULDIV;
            cnt_d     = CNT_W'(MULDIV_LAT - 2);
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
            stall_e_c = 1'b1;
            flush_m_c = 1'b1;
          end else if (load_use) begin
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
            flush_e_c = 1'b1;
          end
        end
        ST_MULDIV: begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          stall_e_c = 1'b1;
          flush_m_c = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if ((freeze | stall_f_c) && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      pend_jb_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_jb_q   <= pend_jb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Gating with rst_n forces every control low during reset, including the comb freeze path.
  assign hz.stall_f     = rst_n & stall_f_c;
  assign hz.stall_d     = rst_n & stall_d_c;
  assign hz.stall_e     = rst_n & stall_e_c;
  assign hz.flush_d     = rst_n & flush_d_c;
  assign hz.flush_e     = rst_n & flush_e_c;
  assign hz.flush_m     = rst_n & flush_m_c;
  assign hz.cache_stall = rst_n & freeze;
  assign hz.muldiv_busy = rst_n & (state_q == ST_MULDIV);
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.dbg_state   = state_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios, a cycle-level reference model checked every
// cycle, and literal expectations for the documented scenarios.
module tb_pipe_hazard_ctrl;
  localparam int LAT    = 4;
  localparam int RA_W   = 5;
  localparam int PERF_W = 16;
  localparam int CNT_MAX = (1 << PERF_W) - 1;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  pipe_hazard_if #(.RA_W(RA_W), .PERF_W(PERF_W)) hz ();

  pipe_hazard_ctrl #(.MULDIV_LAT(LAT), .RA_W(RA_W), .PERF_W(PERF_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Model state: remaining mul/div hold cycles after the start cycle, pending redirect, stall count.
  int   m_hold;
  int   m_cnt;
  logic m_pend;

  always @(negedge clk) begin : cmp
    logic frz, lu;
    logic e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_cs, e_busy;
    e_sf = 0; e_sd = 0; e_se = 0; e_fd = 0; e_fe = 0; e_fm = 0; e_cs = 0; e_busy = 0;
    frz = hz.icache_stall | hz.dcache_stall;
    lu  = hz.ex_is_load && hz.ex_rd != 0 &&
          ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
    if (!rst_n) begin
      m_hold = 0; m_cnt = 0; m_pend = 0;
    end else begin
      e_cs   = frz;
      e_busy = (m_hold > 0);
      if (frz) begin
        m_pend = m_pend | hz.ex_jb;
      end else begin
        if (m_hold > 0) begin
          e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1;
          m_hold = m_hold - 1;
        end else if (hz.ex_jb || m_pend) begin
          e_fd = 1; e_fe = 1;
        end else if (hz.ex_muldiv) begin
          e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1;
          m_hold = LAT - 1;
        end else if (lu) begin
          e_sf = 1; e_sd = 1; e_fe = 1;
        end
        m_pend = 0;
      end
    end
    chk("stall_f",     hz.stall_f,     e_sf);
    chk("stall_d",     hz.stall_d,     e_sd);
    chk("stall_e",     hz.stall_e,     e_se);
    chk("flush_d",     hz.flush_d,     e_fd);
    chk("flush_e",     hz.flush_e,     e_fe);
    chk("flush_m",     hz.flush_m,     e_fm);
    chk("cache_stall", hz.cache_stall, e_cs);
    chk("muldiv_busy", hz.muldiv_busy, e_busy);
    chk("stall_cnt",   hz.stall_cnt,   m_cnt);
    if (rst_n && (frz || e_sf) && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  int n_hold, n_busy, n_fd, n_se;

  task automatic clear_inputs();
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
    hz.ex_rd = '0; hz.ex_is_load = 0; hz.ex_jb = 0; hz.ex_muldiv = 0;
    hz.icache_stall = 0; hz.dcache_stall = 0;
  endtask

  task automatic clear_tally();
    n_hold = 0; n_busy = 0; n_fd = 0; n_se = 0;
  endtask

  // One cycle: observe at the falling edge, then move inputs just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (hz.stall_e || hz.cache_stall) n_hold++;
    if (hz.muldiv_busy) n_busy++;
    if (hz.flush_d) n_fd++;
    if (hz.stall_e) n_se++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    checks = 0;
    failures = 0;
    clear_inputs();
    rst_n = 0;
    #3;
    chk("reset_stall_f", hz.stall_f, 0);
    chk("reset_cnt", hz.stall_cnt, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    tick();

    // Load-use on rs1: one bubble.
    hz.ex_is_load = 1; hz.ex_rd = 5; hz.id_rs1 = 5; hz.id_use_rs1 = 1;
    @(negedge clk);
    chk("lu_stall_f", hz.stall_f, 1);
    chk("lu_stall_d", hz.stall_d, 1);
    chk("lu_flush_e", hz.flush_e, 1);
    chk("lu_stall_e", hz.stall_e, 0);
    @(posedge clk); #1;
    // Same hit through rs2 only.
    hz.id_use_rs1 = 0; hz.id_rs2 = 5; hz.id_use_rs2 = 1;
    @(negedge clk);
    chk("lu_rs2_stall_f", hz.stall_f, 1);
    @(posedge clk); #1;
    // x0 never creates a hazard.
    hz.ex_rd = 0; hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_use_rs1 = 1;
    @(negedge clk);
    chk("lu_x0_stall_f", hz.stall_f, 0);
    chk("lu_x0_flush_e", hz.flush_e, 0);
    @(posedge clk); #1;

    // Redirect wins over a load-use hit.
    hz.ex_rd = 7; hz.id_rs1 = 7; hz.ex_jb = 1;
    @(negedge clk);
    chk("jb_flush_d", hz.flush_d, 1);
    chk("jb_flush_e", hz.flush_e, 1);
    chk("jb_stall_f", hz.stall_f, 0);
    chk("jb_stall_d", hz.stall_d, 0);
    @(posedge clk); #1;
    clear_inputs();
    tick();

    // Mul/div: 4 hold cycles, 3 busy cycles.
    clear_tally();
    hz.ex_muldiv = 1;
    tick();
    hz.ex_muldiv = 0;
    repeat (5) tick();
    chk("md_hold_cycles", n_se, 4);
    chk("md_busy_cycles", n_busy, 3);

    // Redirect during a 3-cycle D-cache freeze is applied once on release.
    clear_tally();
    hz.ex_jb = 1; hz.dcache_stall = 1;
    repeat (3) tick();
    chk("frz_no_flush", n_fd, 0);
    hz.ex_jb = 0; hz.dcache_stall = 0;
    @(negedge clk);
    chk("frz_release_flush_d", hz.flush_d, 1);
    chk("frz_release_flush_e", hz.flush_e, 1);
    @(posedge clk); #1;
    clear_tally();
    repeat (2) tick();
    chk("frz_flush_once", n_fd, 0);

    // I-cache freeze inside mul/div extends the hold to 6 cycles.
    do_reset();
    clear_tally();
    hz.ex_muldiv = 1;
    tick();
    hz.ex_muldiv = 0;
    tick();
    hz.icache_stall = 1;
    repeat (2) tick();
    hz.icache_stall = 0;
    repeat (4) tick();
    chk("md_frz_hold_cycles", n_hold, 6);
    chk("md_frz_stall_cnt", hz.stall_cnt, 6);

    // Reset in the middle of mul/div and a freeze.
    hz.ex_muldiv = 1;
    tick();
    hz.ex_muldiv = 0;
    tick();
    rst_n = 0; hz.icache_stall = 1; hz.ex_jb = 1;
    #1;
    chk("rst_busy", hz.muldiv_busy, 0);
    chk("rst_stall_e", hz.stall_e, 0);
    chk("rst_cache_stall", hz.cache_stall, 0);
    chk("rst_stall_cnt", hz.stall_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1; hz.icache_stall = 0; hz.ex_jb = 0;
    @(negedge clk);
    chk("post_rst_busy", hz.muldiv_busy, 0);
    chk("post_rst_flush_d", hz.flush_d, 0);
    chk("post_rst_stall_cnt", hz.stall_cnt, 0);
    @(posedge clk); #1;

    // Saturation of the stall counter.
    hz.icache_stall = 1;
    repeat (CNT_MAX + 4) begin
      @(posedge clk); #1;
    end
    hz.icache_stall = 0;
    @(negedge clk);
    chk("stall_cnt_saturated", hz.stall_cnt, CNT_MAX);
    @(posedge clk); #1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
